lfsr_gen: RTL and testbench

- Parametrised Fibonacci LFSR for pseudo-random pattern generation and BIST stimulus; successor to the fixed 4-bit seeded LFSR.
- Generalised in WIDTH and tap polynomial.
- Adds an on-clock prescaler strobe in place of a divided clock, run/single-step control, and zero-lockup protection.
- Adds a wrap flag when the sequence returns to the loaded seed.

---
 rtl/lfsr_gen.sv | 126 ++++++++++++
 tb/tb_lfsr_gen.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR with prescaler strobe, run/step control, wrap and lockup flags.
// Optional advance-count period output enabled by defining LFSR_PERIOD_CNT_EN.
module lfsr_gen #(
  parameter int unsigned          WIDTH      = 4,
  parameter logic [WIDTH-1:0]     TAPS       = WIDTH'(4'b1100),
  parameter int unsigned          DIV        = 1,
  parameter logic [WIDTH-1:0]     RESET_SEED = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             run,
  input  logic             step,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  output logic             wrap,
`ifdef LFSR_PERIOD_CNT_EN
  output logic [WIDTH-1:0] period,
`endif
  output logic             lockup
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] TICK_AT = CNT_W'(DIV - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic [CNT_W-1:0] pre_q, pre_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;
  logic             lockup_q, lockup_d;
  logic [WIDTH-1:0] shifted;
  logic             tick;
  logic             adv;
  logic             seed_zero;

`ifdef LFSR_PERIOD_CNT_EN
  logic [WIDTH-1:0] adv_cnt_q, adv_cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
`endif

  // Next-state: load beats a run tick, which beats a single step.
  always_comb begin
    shifted   = {q_q[WIDTH-2:0], ^(q_q & TAPS)};
    tick      = run && (pre_q == TICK_AT);
    adv       = !load && (run ? tick : step);
    seed_zero = (seed == '0);

    q_d      = q_q;
    seed_d   = seed_q;
    pre_d    = '0;
    valid_d  = 1'b0;
    wrap_d   = 1'b0;
    lockup_d = lockup_q;
`ifdef LFSR_PERIOD_CNT_EN
    adv_cnt_d = adv_cnt_q;
    period_d  = period_q;
`endif

    if (run && !tick) begin
      pre_d = pre_q + CNT_W'(1);
    end

    if (load) begin
      pre_d    = '0;
      q_d      = seed_zero ? RESET_SEED : seed;
      seed_d   = seed_zero ? RESET_SEED : seed;
      lockup_d = seed_zero;
      valid_d  = 1'b1;
`ifdef LFSR_PERIOD_CNT_EN
      adv_cnt_d = '0;
`endif
    end else if (adv) begin
      q_d     = shifted;
      valid_d = 1'b1;
      wrap_d  = (shifted == seed_q);
`ifdef LFSR_PERIOD_CNT_EN
      if (shifted == seed_q) begin
        period_d  = adv_cnt_q + WIDTH'(1);
        adv_cnt_d = '0;
      end else begin
        adv_cnt_d = adv_cnt_q + WIDTH'(1);
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q      <= RESET_SEED;
      seed_q   <= RESET_SEED;
      pre_q    <= '0;
      valid_q  <= 1'b0;
      wrap_q   <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      q_q      <= q_d;
      seed_q   <= seed_d;
      pre_q    <= pre_d;
      valid_q  <= valid_d;
      wrap_q   <= wrap_d;
      lockup_q <= lockup_d;
    end
  end

`ifdef LFSR_PERIOD_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      adv_cnt_q <= '0;
      period_q  <= '0;
    end else begin
      adv_cnt_q <= adv_cnt_d;
      period_q  <= period_d;
    end
  end

  assign period = period_q;
`endif

  assign q      = q_q;
  assign valid  = valid_q;
  assign wrap   = wrap_q;
  assign lockup = lockup_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Bench for lfsr_gen: DIV=1 and DIV=3 instances on shared stimulus, checked against a sequence model.
module tb_lfsr_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       load, run, step;
  logic [3:0] seed;

  logic [3:0] dq0, dq1;
  logic       dvalid0, dvalid1, dwrap0, dwrap1, dlock0, dlock1;
`ifdef LFSR_PERIOD_CNT_EN
  logic [3:0] dper0, dper1;
`endif

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  lfsr_gen #(.WIDTH(4), .TAPS(4'b1100), .DIV(1), .RESET_SEED(4'd1)) u_div1 (
    .clk(clk), .rst(rst), .load(load), .seed(seed), .run(run), .step(step),
    .q(dq0), .valid(dvalid0), .wrap(dwrap0),
`ifdef LFSR_PERIOD_CNT_EN
    .period(dper0),
`endif
    .lockup(dlock0));

  lfsr_gen #(.WIDTH(4), .TAPS(4'b1100), .DIV(3), .RESET_SEED(4'd1)) u_div3 (
    .clk(clk), .rst(rst), .load(load), .seed(seed), .run(run), .step(step),
    .q(dq1), .valid(dvalid1), .wrap(dwrap1),
`ifdef LFSR_PERIOD_CNT_EN
    .period(dper1),
`endif
    .lockup(dlock1));

  // Behavioural model: one entry per instance
  localparam int DIVS [2] = '{1, 3};
  logic [3:0] m_q [2];
  logic [3:0] m_seed [2];
  int         m_cnt [2];
  bit         m_valid [2];
  bit         m_wrap [2];
  bit         m_lock [2];
  int         m_nadv [2];
  int         m_period [2];

  function automatic logic [3:0] nxt(input logic [3:0] v);
    int ones;
    ones = $countones(v & 4'b1100);
    return 4'((int'(v) * 2) % 16 + ones % 2);
  endfunction

  function automatic bit is_tick(input int k);
    return run && (m_cnt[k] == DIVS[k] - 1);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        m_q[k] <= 4'd1; m_seed[k] <= 4'd1; m_cnt[k] <= 0;
        m_valid[k] <= 1'b0; m_wrap[k] <= 1'b0; m_lock[k] <= 1'b0;
        m_nadv[k] <= 0; m_period[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (load) begin
          m_q[k]    <= (seed == 4'd0) ? 4'd1 : seed;
          m_seed[k] <= (seed == 4'd0) ? 4'd1 : seed;
          m_cnt[k]  <= 0;
          m_valid[k] <= 1'b1;
          m_wrap[k]  <= 1'b0;
          m_lock[k]  <= (seed == 4'd0);
          m_nadv[k]  <= 0;
        end else begin
          m_cnt[k] <= (run && !is_tick(k)) ? m_cnt[k] + 1 : 0;
          if (run ? is_tick(k) : step) begin
            m_q[k]     <= nxt(m_q[k]);
            m_valid[k] <= 1'b1;
            m_wrap[k]  <= (nxt(m_q[k]) == m_seed[k]);
            if (nxt(m_q[k]) == m_seed[k]) begin
              m_period[k] <= (m_nadv[k] + 1) % 16;
              m_nadv[k]   <= 0;
            end else begin
              m_nadv[k] <= m_nadv[k] + 1;
            end
          end else begin
            m_valid[k] <= 1'b0;
            m_wrap[k]  <= 1'b0;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model
  always @(posedge clk) begin
    #1;
    if (rst && chk_en) begin
      chk("cyc_q0", dq0, m_q[0]);         chk("cyc_q1", dq1, m_q[1]);
      chk("cyc_valid0", dvalid0, m_valid[0]); chk("cyc_valid1", dvalid1, m_valid[1]);
      chk("cyc_wrap0", dwrap0, m_wrap[0]);   chk("cyc_wrap1", dwrap1, m_wrap[1]);
      chk("cyc_lock0", dlock0, m_lock[0]);   chk("cyc_lock1", dlock1, m_lock[1]);
`ifdef LFSR_PERIOD_CNT_EN
      chk("cyc_per0", dper0, 32'(m_period[0])); chk("cyc_per1", dper1, 32'(m_period[1]));
`endif
    end
  end

  logic [3:0] seq_tbl [15] = '{4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110, 4'b1101, 4'b1010,
                               4'b0101, 4'b1011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000,
                               4'b0001};
  logic [3:0] div3_tbl [9] = '{4'h8, 4'h8, 4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2, 4'h4};

  initial begin
    int vcnt;
    rst = 1'b1; load = 1'b0; run = 1'b0; step = 1'b0; seed = 4'd0;
    #1 rst = 1'b0;
    #11;
    chk("rst_q", dq0, 4'd1); chk("rst_valid", dvalid0, 0);
    chk("rst_wrap", dwrap0, 0); chk("rst_lock", dlock0, 0);
    @(negedge clk) rst = 1'b1;
    chk_en = 1'b1;

    // Full period at DIV=1
    @(negedge clk) begin load = 1'b1; seed = 4'b0001; end
    @(negedge clk) begin load = 1'b0; run = 1'b1; end
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("seq_q", dq0, seq_tbl[i]);
      chk("model_seq", m_q[0], seq_tbl[i]);
      chk("seq_wrap", dwrap0, 32'(i == 14));
    end
`ifdef LFSR_PERIOD_CNT_EN
    chk("period15", dper0, 15);
`endif
    run = 1'b0;

    // Prescaled advance at DIV=3
    @(negedge clk) begin load = 1'b1; seed = 4'b1000; end
    @(negedge clk) begin load = 1'b0; run = 1'b1; end
    vcnt = 0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      chk("div3_q", dq1, div3_tbl[k]);
      vcnt += int'(dvalid1);
    end
    chk("div3_valid_pulses", vcnt, 3);
    run = 1'b0;

    // Single-step: high 1, low 4, high 2
    @(negedge clk) begin load = 1'b1; seed = 4'b0110; end
    @(negedge clk) begin load = 1'b0; step = 1'b1; end
    @(negedge clk);
    chk("step_q1", dq0, 4'b1101);
    vcnt = int'(dvalid0);
    step = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("step_hold", dq0, 4'b1101);
      vcnt += int'(dvalid0);
    end
    step = 1'b1;
    @(negedge clk);
    chk("step_q2", dq0, 4'b1010);
    vcnt += int'(dvalid0);
    @(negedge clk);
    chk("step_q3", dq0, 4'b0101);
    vcnt += int'(dvalid0);
    step = 1'b0;
    chk("step_valid_pulses", vcnt, 3);

    // Zero-seed lockup substitution and clearing
    @(negedge clk) begin load = 1'b1; seed = 4'b0000; end
    @(negedge clk) load = 1'b0;
    chk("zero_q", dq0, 4'b0001); chk("zero_lock", dlock0, 1);
    @(negedge clk) begin load = 1'b1; seed = 4'b0101; end
    @(negedge clk) load = 1'b0;
    chk("nz_q", dq0, 4'b0101); chk("nz_lock", dlock0, 0);
    @(negedge clk) begin load = 1'b1; seed = 4'b0000; end
    @(negedge clk) begin load = 1'b0; run = 1'b1; end
    @(negedge clk);
    @(negedge clk);
    chk("lock_sticky", dlock0, 1);

    // Asynchronous reset between edges
    #2 rst = 1'b0;
    #1;
    chk("arst_q0", dq0, 4'd1); chk("arst_valid0", dvalid0, 0);
    chk("arst_wrap0", dwrap0, 0); chk("arst_lock0", dlock0, 0);
    chk("arst_q1", dq1, 4'd1); chk("arst_lock1", dlock1, 0);
    @(negedge clk) begin rst = 1'b1; run = 1'b0; end

    // Load wins over run tick and step in the same cycle
    @(negedge clk) run = 1'b1;
    @(negedge clk);
    @(negedge clk) begin load = 1'b1; seed = 4'b1111; step = 1'b1; end
    @(negedge clk) begin load = 1'b0; step = 1'b0; run = 1'b0; end
    chk("prio_q", dq0, 4'b1111); chk("prio_wrap", dwrap0, 0);
    chk("prio_valid", dvalid0, 1); chk("prio_q1", dq1, 4'b1111);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
